// File: rtl/load_store_unit.sv
// RV32I data-memory LSU: lane formatting, req/ack handshake, load extension; issue->DONE 3 cycles + mem wait.
// Stalls the core until mem_ack_i; optional LSU_MISALIGN_TRAP_EN skips misaligned accesses and pulses misaligned_o.
module load_store_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int FUNCTION3  = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_i,
  input  logic                  store_i,
  input  logic [FUNCTION3-1:0]  fun3_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  stall_o,
  output logic                  dm_valid_o,
  output logic [DATA_WIDTH-1:0] load_data_o,
  output logic                  misaligned_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [3:0]            mem_wstrb_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_ack_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]            r_state;
  logic                  r_is_load;
  logic [FUNCTION3-1:0]  r_fun3;
  logic [1:0]            r_off;
  logic                  r_mem_req;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [3:0]            r_wstrb;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_dm_valid;
  logic [DATA_WIDTH-1:0] r_load_data;
  logic                  r_mis;

  logic                  w_start;
  logic                  w_trap;
  logic [3:0]            w_wstrb;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [DATA_WIDTH-1:0] w_ext;

  assign w_start = load_i | store_i;

`ifdef LSU_MISALIGN_TRAP_EN
  logic w_misaligned;
  assign w_misaligned = ((fun3_i[1:0] == 2'b01) && addr_i[0]) ||
                        ((fun3_i == 3'b010) && (addr_i[1:0] != 2'b00));
  assign w_trap = w_misaligned;
`else
  assign w_trap = 1'b0;
`endif

  // Store data is replicated across lanes; strobes pick the lane(s) actually written.
  always_comb begin
    w_wstrb = 4'b0000;
    w_wdata = wdata_i;
    case (fun3_i)
      3'b000: begin
        w_wstrb = 4'b0001 << addr_i[1:0];
        w_wdata = {4{wdata_i[7:0]}};
      end
      3'b001: begin
        w_wstrb = 4'b0011 << {addr_i[1], 1'b0};
        w_wdata = {2{wdata_i[15:0]}};
      end
      3'b010:  w_wstrb = 4'b1111;
      default: w_wstrb = 4'b0000;
    endcase
  end

  assign w_byte = mem_rdata_i[{r_off, 3'b000} +: 8];
  assign w_half = r_off[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];

  always_comb begin
    w_ext = mem_rdata_i;
    case (r_fun3)
      3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_ext = {24'd0, w_byte};
      3'b001:  w_ext = {{16{w_half[15]}}, w_half};
      3'b101:  w_ext = {16'd0, w_half};
      default: w_ext = mem_rdata_i;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_is_load   <= 1'b0;
      r_fun3      <= '0;
      r_off       <= 2'b00;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_wstrb     <= 4'b0000;
      r_wdata     <= '0;
      r_dm_valid  <= 1'b0;
      r_load_data <= '0;
      r_mis       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_dm_valid <= 1'b0;
          r_mis      <= 1'b0;
          if (w_start) begin
            r_is_load <= load_i;
            r_fun3    <= fun3_i;
            r_off     <= addr_i[1:0];
            if (w_trap) begin
              // Trapped access: no memory cycle, but a load still completes with zero data.
              r_state    <= S_DONE;
              r_mis      <= 1'b1;
              r_dm_valid <= load_i;
              if (load_i) r_load_data <= '0;
            end else begin
              r_state    <= S_WAIT;
              r_mem_req  <= 1'b1;
              r_mem_we   <= ~load_i;
              r_mem_addr <= {addr_i[ADDR_WIDTH-1:2], 2'b00};
              r_wstrb    <= load_i ? 4'b0000 : w_wstrb;
              r_wdata    <= w_wdata;
            end
          end
        end
        S_WAIT: begin
          if (mem_ack_i) begin
            r_mem_req <= 1'b0;
            r_state   <= S_DONE;
            if (r_is_load) begin
              r_load_data <= w_ext;
              r_dm_valid  <= 1'b1;
            end
          end
        end
        S_DONE: begin
          r_dm_valid <= 1'b0;
          r_mis      <= 1'b0;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign stall_o      = ((r_state == S_IDLE) && w_start) || (r_state == S_WAIT);
  assign dm_valid_o   = r_dm_valid;
  assign load_data_o  = r_load_data;
  assign misaligned_o = r_mis;
  assign mem_req_o    = r_mem_req;
  assign mem_we_o     = r_mem_we;
  assign mem_addr_o   = r_mem_addr;
  assign mem_wstrb_o  = r_wstrb;
  assign mem_wdata_o  = r_wdata;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits directly downstream of the control decoder in the single-cycle RV32I core, between the ALU/register file and data memory.
- Takes the Load/Store strobes, fun3, ALU-computed address and rs2 store data, and runs a request/acknowledge transaction to data memory.
- Stalls the core until the transaction completes.
- Returns lane-aligned, sign/zero-extended load data and the one-cycle DM_valid pulse that the control decoder uses to drop Load and enable register write.

Parameters:
- ADDR_WIDTH, 32, byte-address width.
- DATA_WIDTH, 32, data width; only 32 is supported.
- FUNCTION3, 3, fun3 width.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous active-high reset.
- load_i  input  1  load request from control decoder (already gated low by dm_valid_o).
- store_i  input  1  store request from control decoder.
- fun3_i  input  FUNCTION3  access size/sign.
- addr_i  input  ADDR_WIDTH  byte address (ALU result).
- wdata_i  input  DATA_WIDTH  store data (rs2).
- stall_o  output  1  hold PC/pipeline.
- dm_valid_o  output  1  load data valid, one-cycle pulse.
- load_data_o  output  DATA_WIDTH  extended load result.
- misaligned_o  output  1  misaligned-access pulse (only with the optional feature; tied 0 otherwise).
- mem_req_o  output  1  memory request.
- mem_we_o  output  1  1 = write.
- mem_addr_o  output  ADDR_WIDTH  word address, {addr[31:2],2'b00}.
- mem_wstrb_o  output  4  byte-write strobes.
- mem_wdata_o  output  DATA_WIDTH  lane-replicated write data.
- mem_ack_i  input  1  memory done; rdata valid the same cycle.
- mem_rdata_i  input  DATA_WIDTH  read word.

Behaviour:
- Reset:
  - One clk edge with reset=1 forces state IDLE.
  - All registered outputs go to 0: mem_req_o, mem_we_o, mem_addr_o, mem_wstrb_o, mem_wdata_o, dm_valid_o, load_data_o, misaligned_o.
  - Reset mid-transaction abandons it; mem_req_o is 0 after that edge and a late mem_ack_i is ignored.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - On load_i|store_i, register addr, fun3, type, lane-formatted wdata and wstrb, set mem_req_o=1 and mem_we_o=store_i, then go to WAIT.
  - Load has priority if both strobes are high; this case is treated as a load.
- WAIT:
  - All mem_* outputs are held stable.
  - On mem_ack_i: capture and extend mem_rdata_i into load_data_o, clear mem_req_o, go to DONE.
  - No timeout.
- DONE:
  - One cycle; dm_valid_o=1 for loads only, then return to IDLE.
  - load_i/store_i are ignored in DONE, so a still-high store_i does not re-issue.
  - A back-to-back access from the next instruction issues from IDLE on the following cycle.
- stall_o is combinational: (IDLE & (load_i|store_i)) | WAIT. It is 0 in DONE, so PC advances at the end of DONE.
- Latency: ack in the first WAIT cycle gives issue→DONE in 3 cycles. Each extra wait cycle adds 1.
- mem_ack_i is ignored in IDLE and DONE.
- load_data_o holds its value until the next load completes.
- Store lanes (off = addr[1:0]):
  - SB (000): wstrb = 0001<<off, wdata = {4{b}}.
  - SH (001): wstrb = 0011<<(2*addr[1]), wdata = {2{h}}.
  - SW (010): wstrb = 1111.
  - Any other fun3: wstrb = 0000; the transaction still handshakes.
- Load extract:
  - LB (000) / LBU (100): byte[off], sign-/zero-extended.
  - LH (001) / LHU (101): half[addr[1]], sign-/zero-extended.
  - LW (010): full word.
  - Other fun3 values return the full word.
- Misalignment definition: halfword with addr[0]=1, or word with addr[1:0]≠0.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined:
  - A misaligned access issues no memory request; IDLE goes straight to DONE.
  - misaligned_o pulses 1 in DONE.
  - For loads, dm_valid_o pulses with load_data_o=0 so the core does not hang.
  - Stores perform no write.
- Undefined:
  - Misaligned accesses proceed normally. Halfword lanes use addr[1] only; word accesses ignore addr[1:0].
  - misaligned_o is constant 0.

Test Plan:
- LW addr 0x100, mem ack 2 cycles after req, rdata 0xDEADBEEF -> stall_o high 3 cycles; mem_addr_o=0x100, mem_we_o=0; DONE: dm_valid_o=1, load_data_o=0xDEADBEEF.
- LB addr 0x203 / LBU addr 0x203, rdata 0x80AABBCC -> load_data_o=0xFFFFFF80 / 0x00000080.
- SH addr 0x302, wdata 0x0000ABCD, immediate ack -> mem_wstrb_o=1100, mem_wdata_o=0xABCDABCD, mem_we_o=1; dm_valid_o stays 0; store_i held high through DONE causes no second request.
- Back-to-back SW 0x10 then LW 0x10, rdata 0x12345678 -> two distinct requests; second issues the cycle after first DONE; dm_valid_o once with 0x12345678.
- reset asserted in WAIT, then mem_ack_i pulsed -> mem_req_o=0 after the reset edge; dm_valid_o never pulses; FSM in IDLE.
- LW addr 0x102 with LSU_MISALIGN_TRAP_EN -> no mem_req_o; misaligned_o=1 and dm_valid_o=1 with load_data_o=0 two cycles after issue. Without the macro -> request to 0x100, full word returned.
